// File: rtl/systolic_array_os.sv
// systolic_array_os: output-stationary NxN signed MAC array with input skew and row-serial drain.
// Define SYSTOLIC_SAT_EN to clamp each accumulate instead of wrapping.
module systolic_array_os #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 21,
  parameter int K_WIDTH    = 9
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             start,
  input  logic [K_WIDTH-1:0]               k_len,
  output logic                             busy,
  output logic                             done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] d_col,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0]    out_row,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data
);
  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t                r_state;
  logic [K_WIDTH-1:0]    r_klen;
  logic [K_WIDTH-1:0]    r_cnt;
  logic [FW-1:0]         r_fcnt;
  logic [RW-1:0]         r_row;
  logic                  r_done;
  logic signed [DW-1:0]  r_dsk [N][N];
  logic signed [DW-1:0]  r_wsk [N][N];
  logic                  r_vsk [N][N];
  logic signed [DW-1:0]  r_d   [N][N];
  logic signed [DW-1:0]  r_w   [N][N];
  logic                  r_v   [N][N];
  logic signed [AW-1:0]  r_acc [N][N];
  logic signed [DW-1:0]  w_dl  [N];
  logic signed [DW-1:0]  w_wl  [N];
  logic                  w_vl  [N];
  logic signed [DW-1:0]  w_din [N][N];
  logic signed [DW-1:0]  w_win [N][N];
  logic                  w_vin [N][N];
  logic signed [AW-1:0]  w_sum [N][N];
  logic                  w_go;
  logic                  w_beat;

  assign w_go      = (r_state == IDLE) && start;
  assign w_beat    = (r_state == LOAD) && in_valid;
  assign busy      = r_state != IDLE;
  assign in_ready  = r_state == LOAD;
  assign out_valid = r_state == DRAIN;
  assign done      = r_done;
  assign out_row   = r_row;

  // Lane 0 bypasses the skew pipe; lane i taps stage i-1 for an i-cycle delay.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dl[i] = (i == 0) ? d_col[DW-1:0] : r_dsk[i][(i == 0) ? 0 : i - 1];
      w_wl[i] = (i == 0) ? w_row[DW-1:0] : r_wsk[i][(i == 0) ? 0 : i - 1];
      w_vl[i] = (i == 0) ? w_beat : r_vsk[i][(i == 0) ? 0 : i - 1];
    end
  end

  always_comb begin
    logic signed [2*DW-1:0] p;
`ifdef SYSTOLIC_SAT_EN
    logic signed [AW:0] s;
`endif
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_din[i][j] = (j == 0) ? w_dl[i] : r_d[i][(j == 0) ? 0 : j - 1];
        w_vin[i][j] = (j == 0) ? w_vl[i] : r_v[i][(j == 0) ? 0 : j - 1];
        w_win[i][j] = (i == 0) ? w_wl[j] : r_w[(i == 0) ? 0 : i - 1][j];
        p = (2*DW)'(w_din[i][j]) * (2*DW)'(w_win[i][j]);
`ifdef SYSTOLIC_SAT_EN
        s = (AW+1)'(r_acc[i][j]) + (AW+1)'(p);
        w_sum[i][j] = (s[AW] == s[AW-1]) ? s[AW-1:0] :
                      s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`else
        w_sum[i][j] = r_acc[i][j] + AW'(p);
`endif
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++)
      out_data[j*AW +: AW] = out_valid ? r_acc[r_row][j] : '0;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state <= IDLE;
      r_klen  <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_dsk[i][j] <= '0;
          r_wsk[i][j] <= '0;
          r_vsk[i][j] <= 1'b0;
          r_d[i][j]   <= '0;
          r_w[i][j]   <= '0;
          r_v[i][j]   <= 1'b0;
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_dsk[i][0] <= d_col[i*DW +: DW];
        r_wsk[i][0] <= w_row[i*DW +: DW];
        r_vsk[i][0] <= w_beat;
        for (int s = 1; s < N; s++) begin
          r_dsk[i][s] <= r_dsk[i][s-1];
          r_wsk[i][s] <= r_wsk[i][s-1];
          r_vsk[i][s] <= r_vsk[i][s-1];
        end
        for (int j = 0; j < N; j++) begin
          r_d[i][j] <= w_din[i][j];
          r_w[i][j] <= w_win[i][j];
          r_v[i][j] <= w_vin[i][j];
          if (w_go)
            r_acc[i][j] <= '0;
          else if (w_vin[i][j])
            r_acc[i][j] <= w_sum[i][j];
        end
      end
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_klen  <= k_len;
          r_cnt   <= '0;
          r_fcnt  <= '0;
          r_row   <= '0;
          r_state <= (k_len == '0) ? DRAIN : LOAD;
        end
        LOAD: if (in_valid) begin
          r_cnt <= r_cnt + K_WIDTH'(1);
          if (r_cnt + K_WIDTH'(1) == r_klen) begin
            r_fcnt  <= '0;
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_fcnt <= r_fcnt + FW'(1);
          if (r_fcnt == FW'(2*N-2)) r_state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          if (r_row == RW'(N-1)) begin
            r_row   <= '0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_array_os.sv
// tb_systolic_array_os: directed runs on a 21-bit and a 17-bit accumulator array, scoreboarded rows.
module tb_systolic_array_os;
  localparam int N = 8, DW = 8, AW = 21, AW2 = 17, KW = 9;

  logic clk = 1'b0;
  logic srstn, start, in_valid, out_ready;
  logic [KW-1:0] k_len;
  logic [N*DW-1:0] w_row, d_col;
  logic busy, done, in_ready, out_valid;
  logic busy2, done2, in_ready2, out_valid2;
  logic [2:0] out_row, out_row2;
  logic [N*AW-1:0] out_data;
  logic [N*AW2-1:0] out_data2;

  systolic_array_os #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clk(clk), .srstn(srstn), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .w_row(w_row), .d_col(d_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data));

  systolic_array_os #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW2), .K_WIDTH(KW)) dut2 (
    .clk(clk), .srstn(srstn), .start(start), .k_len(k_len), .busy(busy2), .done(done2),
    .in_valid(in_valid), .in_ready(in_ready2), .w_row(w_row), .d_col(d_col),
    .out_valid(out_valid2), .out_ready(out_ready), .out_row(out_row2), .out_data(out_data2));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int bd [16][N];
  int bw [16][N];
  bit vp [32];
  longint m1 [N][N];
  longint m2 [N][N];
  logic [N*AW-1:0] q1 [$];
  logic [N*AW2-1:0] q2 [$];

  function automatic longint step(longint a, longint p, int w);
    longint s, md, mx;
    s  = a + p;
    md = longint'(1) <<< w;
    mx = (md >>> 1) - 1;
`ifdef SYSTOLIC_SAT_EN
    if (s > mx) s = mx;
    else if (s < -(md >>> 1)) s = -(md >>> 1);
`else
    s = s & (md - 1);
    if (s > mx) s = s - md;
`endif
    return s;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rows();
    logic [N*AW-1:0] e1;
    logic [N*AW2-1:0] e2;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e1[j*AW +: AW]   = AW'(m1[i][j]);
        e2[j*AW2 +: AW2] = AW2'(m2[i][j]);
      end
      q1.push_back(e1);
      q2.push_back(e2);
    end
  endtask

  task automatic drain(input int stall_row);
    int rows, budget;
    bit stalled;
    logic [N*AW-1:0] held;
    rows = 0; budget = 0; stalled = 0;
    while (rows < N && budget < 300) begin
      if (out_valid && int'(out_row) == stall_row && !stalled) begin
        out_ready = 0; held = out_data; stalled = 1;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 256'(out_valid), 256'(1));
          chk("stall_row", 256'(out_row), 256'(stall_row));
          chk("stall_data", 256'(out_data), 256'(held));
        end
        out_ready = 1;
      end
      if (out_valid && out_ready) begin
        chk("row_idx", 256'(out_row), 256'(rows));
        chk("row_data", 256'(out_data), q1.size() > 0 ? 256'(q1.pop_front()) : 'x);
        chk("row_data_acc17", 256'(out_data2), q2.size() > 0 ? 256'(q2.pop_front()) : 'x);
        rows++;
      end
      @(negedge clk);
      budget++;
    end
    chk("rows_drained", 256'(rows), 256'(N));
    chk("done_pulse", 256'(done), 256'(1));
    chk("valid_drop", 256'(out_valid), 256'(0));
    chk("busy_idle", 256'(busy), 256'(0));
    @(negedge clk);
    chk("done_single", 256'(done), 256'(0));
    chk("queue_empty", 256'(q1.size()), 256'(0));
  endtask

  task automatic run(input int k, input int plen, input int stall_row);
    int b, lat;
    longint p;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin m1[i][j] = 0; m2[i][j] = 0; end
    @(negedge clk); start = 1; k_len = KW'(k);
    @(negedge clk); start = 0;
    chk("busy_after_start", 256'(busy), 256'(1));
    b = 0;
    if (k == 0) begin
      push_rows();
      chk("k0_direct_drain", 256'(out_valid), 256'(1));
    end else begin
      for (int c = 0; c < plen; c++) begin
        chk("in_ready_load", 256'(in_ready), 256'(1));
        start    = (c == 1);
        in_valid = vp[c];
        for (int i = 0; i < N; i++) begin
          d_col[i*DW +: DW] = vp[c] ? DW'(bd[b][i]) : 8'h37;
          w_row[i*DW +: DW] = vp[c] ? DW'(bw[b][i]) : 8'h4d;
        end
        if (vp[c]) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              p = longint'(bd[b][i]) * longint'(bw[b][j]);
              m1[i][j] = step(m1[i][j], p, AW);
              m2[i][j] = step(m2[i][j], p, AW2);
            end
          b++;
        end
        @(negedge clk);
      end
      start = 0; in_valid = 0; lat = 1;
      push_rows();
      chk("in_ready_flush", 256'(in_ready), 256'(0));
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      chk("latency", 256'(lat), 256'(2*N));
    end
    drain(stall_row);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srstn = 0; start = 0; in_valid = 0; out_ready = 1; k_len = '0; w_row = '0; d_col = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_row", 256'(out_row), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_out_data17", 256'(out_data2), 256'(0));
    srstn = 1;

    for (int i = 0; i < N; i++) begin bd[0][i] = i + 1; bw[0][i] = 1; end
    vp[0] = 1;
    run(1, 1, -1);

    for (int k = 0; k < 8; k++) begin
      vp[k] = 1;
      for (int i = 0; i < N; i++) begin bd[k][i] = -128; bw[k][i] = -128; end
    end
    run(8, 8, -1);

    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) begin bd[k][i] = 2; bw[k][i] = 3; end
    vp[0] = 1; vp[1] = 0; vp[2] = 1; vp[3] = 0; vp[4] = 1; vp[5] = 1;
    run(4, 6, -1);

    for (int k = 0; k < 3; k++) begin
      vp[k] = 1;
      for (int i = 0; i < N; i++) begin
        bd[k][i] = int'($urandom_range(255)) - 128;
        bw[k][i] = int'($urandom_range(255)) - 128;
      end
    end
    run(3, 3, 3);

    run(0, 0, -1);

    @(negedge clk); start = 1; k_len = KW'(4);
    @(negedge clk); start = 0; in_valid = 1; d_col = {N{8'h11}}; w_row = {N{8'h22}};
    @(negedge clk);
    @(negedge clk); srstn = 0; in_valid = 0;
    @(negedge clk);
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_in_ready", 256'(in_ready), 256'(0));
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_done", 256'(done), 256'(0));
    chk("midrst_out_row", 256'(out_row), 256'(0));
    chk("midrst_out_data", 256'(out_data), 256'(0));
    srstn = 1;
    for (int i = 0; i < N; i++) begin bd[0][i] = i - 3; bw[0][i] = i * 5; end
    vp[0] = 1;
    run(1, 1, -1);

    for (int k = 0; k < 4; k++) begin
      vp[k] = 1;
      for (int i = 0; i < N; i++) begin bd[k][i] = -128; bw[k][i] = -128; end
    end
    run(4, 4, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
